// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-synchronises to a Fibonacci LFSR stream, then flywheels
// a local copy to count bit errors and declare loss of lock after consecutive misses.
module lfsr_checker #(
  parameter int             N        = 8,
  parameter logic [N-1:0]   TAPS     = 8'b1011_1000,
  parameter int             LOCK_CNT = 16,
  parameter int             LOSS_CNT = 4,
  parameter int             CW       = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          din_valid,
  input  logic          din,
  input  logic          clr,
  output logic          locked,
  output logic          err_pulse,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] bit_count
);

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  localparam logic [FW-1:0] FILL_FULL  = FW'(N);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e        state_q;
  // hist_q[k-1] holds the bit received k-1 valid bits ago, so bit 0 is the newest.
  logic [N-1:0]  hist_q;
  logic [FW-1:0] fill_q;
  logic [MW-1:0] match_q;
  logic [LW-1:0] miss_q;
  logic [CW-1:0] err_count_q;
  logic [CW-1:0] bit_count_q;
  logic          err_pulse_q;

  logic          pred;
  logic          mismatch;
  logic [CW-1:0] err_count_d;
  logic [CW-1:0] bit_count_d;

  assign pred     = ^(hist_q & TAPS);
  assign mismatch = din ^ pred;

  always_comb begin
    err_count_d = (err_count_q == CNT_MAX) ? err_count_q : err_count_q + CW'(1);
    bit_count_d = (bit_count_q == CNT_MAX) ? bit_count_q : bit_count_q + CW'(1);
  end

  // NOTE: all state updates use non-blocking assignments so every branch reads the
  // pre-edge values; a later assignment to the same register in this block wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          SEARCH: begin
            hist_q <= {hist_q[N-2:0], din};
            if (fill_q != FILL_FULL) begin
              fill_q <= fill_q + FW'(1);
            end else if (!mismatch && (|hist_q)) begin
              match_q <= match_q + MW'(1);
              if (match_q == MATCH_LAST) begin
                state_q <= LOCKED;
                miss_q  <= '0;
              end
            end else begin
              // The all-zero history predicts zero forever, so it must never count.
              match_q <= '0;
            end
          end
          LOCKED: begin
            hist_q      <= {hist_q[N-2:0], pred};
            bit_count_q <= bit_count_d;
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              err_count_q <= err_count_d;
              miss_q      <= miss_q + LW'(1);
              if (miss_q == MISS_LAST) begin
                state_q <= SEARCH;
                hist_q  <= '0;
                fill_q  <= '0;
                match_q <= '0;
                miss_q  <= '0;
              end
            end else begin
              miss_q <= '0;
            end
          end
        endcase
      end
      if (clr) begin
        err_count_q <= '0;
        bit_count_q <= '0;
      end
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a generator model feeds the stream, expected
// outputs are derived from the injected-error pattern and checked every cycle.
module tb_lfsr_checker;

  localparam int           N    = 3;
  localparam logic [N-1:0] TAPS = 3'b110;
  localparam int           LOCK = 8;
  localparam int           LOSS = 4;

  logic clk;
  logic reset_n;
  logic din_valid;
  logic din;
  logic clr;

  logic        locked_a, pulse_a;
  logic [15:0] errc_a, bitc_a;
  logic        locked_b, pulse_b;
  logic [3:0]  errc_b, bitc_b;

  lfsr_checker #(.N(N), .TAPS(TAPS), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CW(16)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .din_valid (din_valid),
    .din       (din),
    .clr       (clr),
    .locked    (locked_a),
    .err_pulse (pulse_a),
    .err_count (errc_a),
    .bit_count (bitc_a)
  );

  lfsr_checker #(.N(N), .TAPS(TAPS), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CW(4)) u_sat (
    .clk       (clk),
    .reset_n   (reset_n),
    .din_valid (din_valid),
    .din       (din),
    .clr       (clr),
    .locked    (locked_b),
    .err_pulse (pulse_b),
    .err_count (errc_b),
    .bit_count (bitc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic locked;
    logic pulse;
    int   errc;
    int   bitc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Expected-behaviour model, expressed in terms of the stimulus rather than the
  // checker's internals: clean stream locks after N+LOCK valid bits from SEARCH,
  // and while locked every injected corruption is exactly one counted error.
  logic         m_locked;
  int           m_search_bits;
  int           m_miss;
  int           m_errc;
  int           m_bitc;
  logic [N-1:0] gen_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    m_locked      = 1'b0;
    m_search_bits = 0;
    m_miss        = 0;
    m_errc        = 0;
    m_bitc        = 0;
    gen_q         = 3'b001;
  endtask

  task automatic gen_bit(output logic b);
    b     = ^(gen_q & TAPS);
    gen_q = {gen_q[N-2:0], b};
  endtask

  task automatic compare_outputs(input exp_t e);
    check("locked",        {31'd0, locked_a}, {31'd0, e.locked});
    check("err_pulse",     {31'd0, pulse_a},  {31'd0, e.pulse});
    check("err_count",     {16'd0, errc_a},   sat(e.errc, 65535));
    check("bit_count",     {16'd0, bitc_a},   sat(e.bitc, 65535));
    check("sat_locked",    {31'd0, locked_b}, {31'd0, e.locked});
    check("sat_err_pulse", {31'd0, pulse_b},  {31'd0, e.pulse});
    check("sat_err_count", {28'd0, errc_b},   sat(e.errc, 15));
    check("sat_bit_count", {28'd0, bitc_b},   sat(e.bitc, 15));
  endtask

  // One clock of stimulus: drive, push the expected post-edge outputs, then pop and
  // compare one time unit after the edge.
  task automatic step(input bit v, input bit corrupt, input bit zero, input bit c);
    logic b;
    exp_t e;
    b = 1'b0;
    if (v && !zero) gen_bit(b);
    din_valid = v;
    din       = b ^ (v & corrupt);
    clr       = c;

    e.pulse = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (!zero) begin
          m_search_bits++;
          if (m_search_bits == N + LOCK) begin
            m_locked = 1'b1;
            m_miss   = 0;
          end
        end
      end else begin
        m_bitc++;
        if (corrupt) begin
          m_errc++;
          m_miss++;
          e.pulse = 1'b1;
          if (m_miss == LOSS) begin
            m_locked      = 1'b0;
            m_search_bits = 0;
            m_miss        = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (c) begin
      m_errc = 0;
      m_bitc = 0;
    end
    e.locked = m_locked;
    e.errc   = m_errc;
    e.bitc   = m_bitc;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      compare_outputs(sb_q.pop_front());
    end
  endtask

  // Asynchronous reset in the middle of a clock phase; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2;
    reset_n   = 1'b0;
    din_valid = 1'b0;
    clr       = 1'b0;
    #1;
    check({tag, "_locked"},    {31'd0, locked_a}, 32'd0);
    check({tag, "_err_pulse"}, {31'd0, pulse_a},  32'd0);
    check({tag, "_err_count"}, {16'd0, errc_a},   32'd0);
    check({tag, "_bit_count"}, {16'd0, bitc_a},   32'd0);
    check({tag, "_sat_err"},   {28'd0, errc_b},   32'd0);
    check({tag, "_sat_bits"},  {28'd0, bitc_b},   32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int lock_at;
  int valid_after_lock;

  initial begin
    reset_n   = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    clr       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_locked",    {31'd0, locked_a}, 32'd0);
    check("reset_err_pulse", {31'd0, pulse_a},  32'd0);
    check("reset_err_count", {16'd0, errc_a},   32'd0);
    check("reset_bit_count", {16'd0, bitc_a},   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero stream must never lock.
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    check("zero_never_locked", {31'd0, locked_a}, 32'd0);
    async_reset("zero_reset");

    // Clean lock: locked rises on the 11th valid edge.
    lock_at = 0;
    for (int i = 1; i <= N + LOCK; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (locked_a && lock_at == 0) lock_at = i;
    end
    check("lock_edge", lock_at, N + LOCK);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("bit_count_100", {16'd0, bitc_a}, 32'd100);
    check("clean_no_errors", {16'd0, errc_a}, 32'd0);

    // Single error: counted once, lock held, no propagation.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("single_err_count", {16'd0, errc_a}, 32'd1);
    check("single_err_locked", {31'd0, locked_a}, 32'd1);

    // Loss after 4 consecutive misses, then re-lock on a clean stream.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < LOSS; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("loss_err_count", {16'd0, errc_a}, 32'd4);
    check("loss_unlocked", {31'd0, locked_a}, 32'd0);
    for (int i = 0; i < N + LOCK; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("relock", {31'd0, locked_a}, 32'd1);
    check("relock_err_count", {16'd0, errc_a}, 32'd4);

    // Gapped valid: drop lock, then re-acquire with ~50% valid.
    for (int i = 0; i < LOSS; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    valid_after_lock = 0;
    for (int i = 0; i < 300; i++) begin
      logic v;
      logic was_locked;
      v = 1'($urandom_range(0, 1));
      was_locked = m_locked;
      step(v, 1'b0, 1'b0, 1'b0);
      if (v && was_locked) valid_after_lock++;
    end
    check("gapped_locked", {31'd0, locked_a}, 32'd1);
    check("gapped_bit_count", {16'd0, bitc_a}, valid_after_lock);
    check("gapped_no_errors", {16'd0, errc_a}, 32'd0);

    // 20 isolated errors: the 4-bit counter holds at 15.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("sat_err_hold", {28'd0, errc_b}, 32'd15);
    check("wide_err_20", {16'd0, errc_a}, 32'd20);
    check("sat_still_locked", {31'd0, locked_b}, 32'd1);

    // clr in the same cycle as an error: count clears, pulse still fires.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_err_pulse", {31'd0, pulse_a}, 32'd1);
    check("clr_err_count", {16'd0, errc_a}, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, (i == 2), 1'b0, 1'b0);

    // Reset mid-stream with live, non-zero outputs.
    async_reset("mid_reset");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
